// File: rtl/core_if_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_if_fetch_pkg
// Description : Shared types, constants and PC helpers for the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package core_if_fetch_pkg;

    localparam int unsigned C_XLEN     = 32;
    localparam logic [31:0] C_INST_NOP = 32'h0000_0013;
    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IF_STATE_REQ  = 2'b00,
        IF_STATE_WAIT = 2'b01,
        IF_STATE_DROP = 2'b10,
        IF_STATE_BUF  = 2'b11
    } if_state_e;

    typedef struct packed {
        logic [C_XLEN-1:0] inst;
        logic [C_XLEN-1:0] addr;
    } if_entry_t;

    // Sequential PC; wraps naturally at 2^32.
    function automatic logic [C_XLEN-1:0] pc_incr(input logic [C_XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

    function automatic logic [C_XLEN-1:0] pc_align(input logic [C_XLEN-1:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage
`default_nettype wire

// File: rtl/core_if_fetch_slot.sv
`default_nettype none
// ============================================================================
// Module      : core_if_fetch_slot
// Description : Output register plus one-entry skid buffer with flush.
// Revision    : 1.0 - initial release
// ============================================================================
module core_if_fetch_slot
    import core_if_fetch_pkg::*;
#(
    parameter logic [31:0] NOP_INST = C_INST_NOP
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_flush,
    input  logic      i_load_out,
    input  logic      i_load_buf,
    input  logic      i_pop_buf,
    input  logic      i_hold,
    input  if_entry_t i_entry,
    output logic      o_valid,
    output if_entry_t o_entry
);

    localparam if_entry_t C_EMPTY = {NOP_INST, 32'h0000_0000};

    logic      r_valid;
    if_entry_t r_entry;
    logic      r_buf_valid;
    if_entry_t r_buf;
    logic      w_pop;

    assign w_pop = i_pop_buf && r_buf_valid;

    // Output register: a valid entry is only kept while decode holds it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_entry <= C_EMPTY;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_entry <= C_EMPTY;
        end else if (i_load_out) begin
            r_valid <= 1'b1;
            r_entry <= i_entry;
        end else if (w_pop) begin
            r_valid <= 1'b1;
            r_entry <= r_buf;
        end else if (!(r_valid && i_hold)) begin
            r_valid <= 1'b0;
            r_entry <= C_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf_valid <= 1'b0;
            r_buf       <= C_EMPTY;
        end else if (i_flush || w_pop) begin
            r_buf_valid <= 1'b0;
        end else if (i_load_buf) begin
            r_buf_valid <= 1'b1;
            r_buf       <= i_entry;
        end
    end

    assign o_valid = r_valid;
    assign o_entry = r_entry;

endmodule
`default_nettype wire

// File: rtl/core_if_fetch.sv
`default_nettype none
// ============================================================================
// Module      : core_if_fetch
// Description : Instruction fetch stage: PC, single-outstanding memory read
//               FSM, redirect/flush and hold-aware output register.
// Revision    : 1.0 - initial release
// ============================================================================
module core_if_fetch
    import core_if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = C_RESET_PC,
    parameter logic [31:0] NOP_INST = C_INST_NOP
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req_out,
    output logic [C_XLEN-1:0] mem_addr_out,
    input  logic              mem_ready_in,
    input  logic              mem_rvalid_in,
    input  logic [C_XLEN-1:0] mem_rdata_in,
    input  logic              jump_en_in,
    input  logic [C_XLEN-1:0] jump_addr_in,
    input  logic              hold_in,
    output logic              inst_valid_out,
    output logic [C_XLEN-1:0] inst_out,
    output logic [C_XLEN-1:0] inst_addr_out
);

    if_state_e         r_state;
    if_state_e         w_state_nxt;
    logic [C_XLEN-1:0] r_pc;

    logic              w_valid;
    if_entry_t         w_entry;
    logic              w_out_free;
    logic              w_accept;
    logic              w_rsp;
    logic              w_load_out;
    logic              w_load_buf;
    logic              w_pop_buf;

    assign w_out_free = !w_valid || !hold_in;

    // No request while in reset, while redirecting, or while decode is stalled on us.
    assign mem_req_out  = !rst && (r_state == IF_STATE_REQ) && !jump_en_in
                          && !(w_valid && hold_in);
    assign mem_addr_out = r_pc;
    assign w_accept     = mem_req_out && mem_ready_in;

    assign w_rsp      = (r_state == IF_STATE_WAIT) && mem_rvalid_in;
    assign w_load_out = w_rsp && w_out_free && !jump_en_in;
    assign w_load_buf = w_rsp && !w_out_free && !jump_en_in;
    assign w_pop_buf  = (r_state == IF_STATE_BUF) && !hold_in && !jump_en_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IF_STATE_REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Redirect outranks every other event in every state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IF_STATE_REQ: begin
                if (!jump_en_in && w_accept) begin
                    w_state_nxt = IF_STATE_WAIT;
                end
            end
            IF_STATE_WAIT: begin
                if (jump_en_in) begin
                    w_state_nxt = mem_rvalid_in ? IF_STATE_REQ : IF_STATE_DROP;
                end else if (mem_rvalid_in) begin
                    w_state_nxt = w_out_free ? IF_STATE_REQ : IF_STATE_BUF;
                end
            end
            IF_STATE_DROP: begin
                if (mem_rvalid_in) begin
                    w_state_nxt = IF_STATE_REQ;
                end
            end
            IF_STATE_BUF: begin
                if (jump_en_in || !hold_in) begin
                    w_state_nxt = IF_STATE_REQ;
                end
            end
            default: begin
                w_state_nxt = IF_STATE_REQ;
            end
        endcase
    end

    // PC only advances once the word for the current PC has returned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (jump_en_in) begin
            r_pc <= pc_align(jump_addr_in);
        end else if (w_rsp) begin
            r_pc <= pc_incr(r_pc);
        end
    end

    core_if_fetch_slot #(
        .NOP_INST (NOP_INST)
    ) u_slot (
        .clk        (clk),
        .rst        (rst),
        .i_flush    (jump_en_in),
        .i_load_out (w_load_out),
        .i_load_buf (w_load_buf),
        .i_pop_buf  (w_pop_buf),
        .i_hold     (hold_in),
        .i_entry    ({mem_rdata_in, r_pc}),
        .o_valid    (w_valid),
        .o_entry    (w_entry)
    );

    assign inst_valid_out = w_valid;
    assign inst_out       = w_entry.inst;
    assign inst_addr_out  = w_entry.addr;

endmodule
`default_nettype wire
